// File: rtl/td_rf_seq.sv
// Sequencer for a tiny register file: timed write pulses, windowed reads that
// count high cycles on the asynchronous outputs A/B, and a timed clear.
module td_rf_seq #(
  parameter int unsigned DW       = 8,
  parameter int unsigned READ_WIN = 255,
  parameter int unsigned CLR_LEN  = 2
) (
  input  logic          clk_i,
  input  logic          rstb_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [1:0]    cmd_op_i,
  input  logic [2:0]    cmd_waddr_i,
  input  logic [DW-1:0] cmd_wdata_i,
  input  logic [2:0]    cmd_ra_i,
  input  logic [2:0]    cmd_rb_i,
  output logic          we_o,
  output logic [2:0]    w_o,
  output logic          fb_o,
  output logic          re_o,
  output logic [2:0]    ra_o,
  output logic [2:0]    rb_o,
  output logic          tdr_rstb_o,
  input  logic          a_i,
  input  logic          b_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_a_o,
  output logic [DW-1:0] rsp_b_o,
  output logic          rsp_ovf_o
);

  localparam int unsigned RWW = $clog2(READ_WIN + 1);
  localparam int unsigned CLW = $clog2(CLR_LEN + 1);
  localparam int unsigned TW0 = (DW > RWW) ? DW : RWW;
  localparam int unsigned TW  = (TW0 > CLW) ? TW0 : CLW;
  localparam logic [DW-1:0] CNT_MAX = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_WSETUP, S_WPULSE, S_WHOLD, S_RSETUP, S_RPULSE, S_RDRAIN, S_RESP, S_CLR
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    cmd_waddr_q, cmd_waddr_d;
  logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [2:0]    cmd_ra_q, cmd_ra_d;
  logic [2:0]    cmd_rb_q, cmd_rb_d;
  logic [DW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic          a_s1_q, a_s2_q, b_s1_q, b_s2_q;

  logic          cmd_ready_q, cmd_ready_d;
  logic          we_q, we_d, re_q, re_d, tdr_rstb_q, tdr_rstb_d;
  logic [2:0]    w_out_q, w_out_d, ra_out_q, ra_out_d, rb_out_q, rb_out_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_ovf_q, rsp_ovf_d;
  logic [DW-1:0] rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;
  logic          rsp_load;

  // Two-flop synchronizers for the asynchronous register-file outputs
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      a_s1_q <= 1'b0;
      a_s2_q <= 1'b0;
      b_s1_q <= 1'b0;
      b_s2_q <= 1'b0;
    end else begin
      a_s1_q <= a_i;
      a_s2_q <= a_s1_q;
      b_s1_q <= b_i;
      b_s2_q <= b_s1_q;
    end
  end

  // Next state, timer, captured command and counters
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    cmd_waddr_d = cmd_waddr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_ra_d    = cmd_ra_q;
    cmd_rb_d    = cmd_rb_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          cmd_waddr_d = cmd_waddr_i;
          cmd_wdata_d = cmd_wdata_i;
          cmd_ra_d    = cmd_ra_i;
          cmd_rb_d    = cmd_rb_i;
          case (cmd_op_i)
            2'b00:   state_d = S_WSETUP;
            2'b01:   state_d = S_RSETUP;
            2'b10: begin
              state_d = S_CLR;
              tmr_d   = TW'(CLR_LEN - 1);
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_WSETUP: begin
        if (cmd_wdata_q == '0) begin
          state_d = S_WHOLD;
        end else begin
          state_d = S_WPULSE;
          tmr_d   = TW'(cmd_wdata_q) - TW'(1);
        end
      end
      S_WPULSE: begin
        if (tmr_q == '0) state_d = S_WHOLD;
        else             tmr_d   = tmr_q - TW'(1);
      end
      S_WHOLD: state_d = S_IDLE;
      S_RSETUP: begin
        cnt_a_d = '0;
        cnt_b_d = '0;
        state_d = S_RPULSE;
        tmr_d   = TW'(READ_WIN - 1);
      end
      S_RPULSE, S_RDRAIN: begin
        if (a_s2_q && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + DW'(1);
        if (b_s2_q && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + DW'(1);
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TW'(1);
        end else if (state_q == S_RPULSE) begin
          state_d = S_RDRAIN;
          tmr_d   = TW'(1);
        end else begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready_i) state_d = S_IDLE;
      end
      S_CLR: begin
        if (tmr_q == '0) state_d = S_IDLE;
        else             tmr_d   = tmr_q - TW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state, registered one cycle later
  always_comb begin
    rsp_load    = (state_q == S_RESP) && !rsp_valid_q;
    cmd_ready_d = (state_d == S_IDLE);
    we_d        = (state_q == S_WPULSE);
    re_d        = (state_q == S_RPULSE);
    tdr_rstb_d  = (state_q != S_CLR);
    w_out_d     = (state_q == S_WSETUP) ? cmd_waddr_q : w_out_q;
    ra_out_d    = (state_q == S_RSETUP) ? cmd_ra_q : ra_out_q;
    rb_out_d    = (state_q == S_RSETUP) ? cmd_rb_q : rb_out_q;
    rsp_valid_d = (state_q == S_RESP) && !(rsp_valid_q && rsp_ready_i);
    rsp_a_d     = rsp_load ? cnt_a_q : rsp_a_q;
    rsp_b_d     = rsp_load ? cnt_b_q : rsp_b_q;
    rsp_ovf_d   = rsp_load ? ((cnt_a_q == CNT_MAX) || (cnt_b_q == CNT_MAX)) : rsp_ovf_q;
  end

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      cmd_waddr_q <= '0;
      cmd_wdata_q <= '0;
      cmd_ra_q    <= '0;
      cmd_rb_q    <= '0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      cmd_ready_q <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      tdr_rstb_q  <= 1'b0;
      w_out_q     <= '0;
      ra_out_q    <= '0;
      rb_out_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      cmd_waddr_q <= cmd_waddr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_ra_q    <= cmd_ra_d;
      cmd_rb_q    <= cmd_rb_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      cmd_ready_q <= cmd_ready_d;
      we_q        <= we_d;
      re_q        <= re_d;
      tdr_rstb_q  <= tdr_rstb_d;
      w_out_q     <= w_out_d;
      ra_out_q    <= ra_out_d;
      rb_out_q    <= rb_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign we_o        = we_q;
  assign w_o         = w_out_q;
  assign fb_o        = 1'b0;
  assign re_o        = re_q;
  assign ra_o        = ra_out_q;
  assign rb_o        = rb_out_q;
  assign tdr_rstb_o  = tdr_rstb_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_a_o     = rsp_a_q;
  assign rsp_b_o     = rsp_b_q;
  assign rsp_ovf_o   = rsp_ovf_q;

endmodule
